// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - two-requester issue controller for a slow multiply/divide unit
module md_issue_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [1:0]  req0_operator_i,
    input  logic [1:0]  req0_signed_mode_i,
    input  logic [31:0] req0_op_a_i,
    input  logic [31:0] req0_op_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [1:0]  req1_operator_i,
    input  logic [1:0]  req1_signed_mode_i,
    input  logic [31:0] req1_op_a_i,
    input  logic [31:0] req1_op_b_i,
    input  logic        kill_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic [5:0]  rsp_cycles_o,
    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    output logic        md_equal_to_zero_o,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

    state_t      state_q;
    logic        prio_q;
    logic [1:0]  op_q;
    logic [1:0]  sm_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        id_q;
    logic [5:0]  cnt_q;

    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        active;
    logic [5:0]  cnt_next;

    // prio_q names the requester that wins when both are valid
    assign gnt0   = req0_valid_i & (~req1_valid_i | ~prio_q);
    assign gnt1   = req1_valid_i & (~req0_valid_i |  prio_q);

    assign req0_ready_o = (state_q == IDLE) & gnt0 & ~kill_i;
    assign req1_ready_o = (state_q == IDLE) & gnt1 & ~kill_i;
    assign accept       = req0_ready_o | req1_ready_o;

    assign active       = (state_q == ISSUE) | (state_q == DRAIN);
    assign md_mult_en_o = active & ~op_q[1];
    assign md_div_en_o  = active &  op_q[1];

    assign md_operator_o      = op_q;
    assign md_signed_mode_o   = sm_q;
    assign md_op_a_o          = a_q;
    assign md_op_b_o          = b_q;
    assign md_equal_to_zero_o = (b_q == 32'd0);

    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_cycles_o = cnt_q;

    assign cnt_next = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            op_q     <= 2'd0;
            sm_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            id_q     <= 1'b0;
            cnt_q    <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= gnt1 ? req1_operator_i    : req0_operator_i;
                        sm_q    <= gnt1 ? req1_signed_mode_i : req0_signed_mode_i;
                        a_q     <= gnt1 ? req1_op_a_i        : req0_op_a_i;
                        b_q     <= gnt1 ? req1_op_b_i        : req0_op_b_i;
                        id_q    <= gnt1;
                        prio_q  <= ~gnt1;
                        cnt_q   <= 6'd0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_next;
                    if (md_valid_i) begin
                        if (kill_i) begin
                            state_q <= IDLE;
                        end else begin
                            result_q <= md_result_i;
                            state_q  <= RESP;
                        end
                    end else if (kill_i) begin
                        state_q <= DRAIN;
                    end
                end
                RESP: begin
                    if (kill_i || rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    // the unit must finish on its own before anything new may start
                    cnt_q <= cnt_next;
                    if (md_valid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
